seq_wide_adder: RTL and testbench
=================================

SEQ_WIDE_ADDER -- requirements
Module: seq_wide_adder

Interface
REQ-001 SHALL have parameter WORDS, default 4: number of 8-bit slices; operand width is 8*WORDS; legal range 2..16.
REQ-002 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1: operand request.
REQ-005 SHALL have port in_ready, output, 1: block can accept an operand.
REQ-006 SHALL have port a, input, 8*WORDS: operand A.
REQ-007 SHALL have port b, input, 8*WORDS: operand B.
REQ-008 SHALL have port cin, input, 1: carry-in.
REQ-009 SHALL have port sub, input, 1: subtract select; present only when ADD_SUB_EN is defined.
REQ-010 SHALL have port out_valid, output, 1: result available.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-012 SHALL have port sum, output, 8*WORDS: result.
REQ-013 SHALL have port cout, output, 1: carry-out of the top slice.
REQ-014 SHALL have port busy, output, 1: high in RUN and DONE.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE, with out_valid=0 in IDLE and RUN.
REQ-017 SHALL accept on in_valid&in_ready: latch a, b and cin, set slice index=0, carry register=cin, and enter RUN.
REQ-018 SHALL, in RUN, add one 8-bit slice per cycle: sum[8i+7:8i] <= a[i]+b[i]+carry, carry <= slice carry-out, i <= i+1.
REQ-019 SHALL, on the RUN cycle with i==WORDS-1, register cout from the slice carry-out and enter DONE.
REQ-020 SHALL assert out_valid exactly WORDS cycles after the accepting edge.
REQ-021 SHALL, in DONE, hold out_valid, sum and cout stable until out_valid&out_ready, then return to IDLE on that edge.
REQ-022 SHALL ignore in_valid during RUN and DONE, with no queueing and no back-to-back overlap; minimum initiation interval is WORDS+2 cycles.
REQ-023 SHALL handle a full carry chain (e.g. all-ones + cin) correctly across every slice boundary.
REQ-024 SHALL leave sum slices not yet computed in RUN holding their previous value; sum is defined only while out_valid=1.
REQ-025 SHALL drive all outputs from registers, except in_ready and busy, which are decoded from the state register.

Reset
REQ-026 SHALL, on rst_n=0 and without waiting for clk, enter IDLE and clear to 0 the operand registers, carry, index, sum, cout, out_valid and busy; in_ready SHALL be 1 while in reset.
REQ-027 SHALL discard any operation in flight when reset is asserted mid-RUN or mid-DONE; no out_valid is produced for it.
REQ-028 SHALL leave IDLE no earlier than the first clk edge after rst_n deasserts.

Configuration
REQ-029 SHALL use the macro ADD_SUB_EN to compile in subtraction.
REQ-030 SHALL, when ADD_SUB_EN is defined, sample sub at acceptance; sub=1 computes a + ~b + 1 (cin ignored) and cout=1 means no borrow.
REQ-031 SHALL, when ADD_SUB_EN is undefined, omit the sub port and its logic and perform add only.

Structure
REQ-032 SHALL place localparam SLICE_W=8 and the FSM state typedef (IDLE/RUN/DONE) in the shared package adder_pkg.
REQ-033 SHALL instantiate one sub-module, add8_slice: a combinational 8-bit carry-skip slice (a8, b8, ci -> s8, co), with skip taken when all four low propagate bits are set.
REQ-034 SHALL multiplex the slice operand by index from the latched registers and contain no other arithmetic outside add8_slice.

Verification (WORDS=4)
REQ-035 SHALL cover: a=0x000000FF, b=0x00000001, cin=0 -> sum=0x00000100, cout=0, out_valid 4 cycles after accept.
REQ-036 SHALL cover: a=0xFFFFFFFF, b=0, cin=1 -> sum=0x00000000, cout=1.
REQ-037 SHALL cover: result held with out_ready=0 for 10 cycles -> sum/cout stable, in_ready=0, a new in_valid pulse is ignored, then the handshake completes and returns to IDLE.
REQ-038 SHALL cover: rst_n pulsed low during RUN slice 2 -> outputs 0 immediately, no out_valid; the next operation a=1, b=2 gives sum=3.
REQ-039 SHALL cover, with ADD_SUB_EN: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0; a=7, b=5, sub=1 -> sum=2, cout=1.
REQ-040 SHALL cover: 1000 random operands with random in_valid/out_ready, checked against a behavioural a+b+cin model, with no lost or duplicated results.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the sequential wide adder: slice width, skip-group
// width and the controller state type.
package adder_pkg;

    localparam int SLICE_W = 8;
    localparam int SKIP_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add8_slice.sv
// Combinational 8-bit carry-skip adder slice. The carry into the upper nibble
// bypasses the lower ripple chain whenever all lower propagate bits are set.
module add8_slice
    import adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a8,
    input  logic [SLICE_W-1:0] b8,
    input  logic               ci,
    output logic [SLICE_W-1:0] s8,
    output logic               co
);

    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;
    logic [SLICE_W:0]   c;

    always_comb begin
        p    = a8 ^ b8;
        g    = a8 & b8;
        c    = '0;
        c[0] = ci;
        for (int k = 0; k < SKIP_W - 1; k++) begin
            c[k+1] = g[k] | (p[k] & c[k]);
        end
        c[SKIP_W] = (&p[SKIP_W-1:0]) ? ci
                                     : (g[SKIP_W-1] | (p[SKIP_W-1] & c[SKIP_W-1]));
        for (int k = SKIP_W; k < SLICE_W; k++) begin
            c[k+1] = g[k] | (p[k] & c[k]);
        end
        s8 = p ^ c[SLICE_W-1:0];
        co = c[SLICE_W];
    end

endmodule

// File: rtl/seq_wide_adder.sv
// Sequential wide adder: one 8-bit slice per cycle, valid/ready on both sides.
// Define ADD_SUB_EN to add the sub port and subtraction (a + ~b + 1).
module seq_wide_adder
    import adder_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SLICE_W*WORDS-1:0] a,
    input  logic [SLICE_W*WORDS-1:0] b,
    input  logic                     cin,
`ifdef ADD_SUB_EN
    input  logic                     sub,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SLICE_W*WORDS-1:0] sum,
    output logic                     cout,
    output logic                     busy
);

    localparam int W     = SLICE_W * WORDS;
    localparam int IDX_W = $clog2(WORDS);

    state_t             state_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       sum_q;
    logic               carry_q;
    logic               cout_q;
    logic               out_valid_q;
    logic [IDX_W-1:0]   idx_q;

    logic [W-1:0]       b_acc;
    logic               c_acc;
    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic [SLICE_W-1:0] s_sl;
    logic               co_sl;

    // Subtraction is folded in at acceptance so the run phase is add-only.
`ifdef ADD_SUB_EN
    assign b_acc = sub ? ~b : b;
    assign c_acc = sub ? 1'b1 : cin;
`else
    assign b_acc = b;
    assign c_acc = cin;
`endif

    assign a_sl = a_q[SLICE_W*int'(idx_q) +: SLICE_W];
    assign b_sl = b_q[SLICE_W*int'(idx_q) +: SLICE_W];

    add8_slice u_slice (
        .a8 (a_sl),
        .b8 (b_sl),
        .ci (carry_q),
        .s8 (s_sl),
        .co (co_sl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            idx_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b_acc;
                        carry_q <= c_acc;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[SLICE_W*int'(idx_q) +: SLICE_W] <= s_sl;
                    carry_q <= co_sl;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(WORDS - 1)) begin
                        cout_q      <= co_sl;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_seq_wide_adder.sv
// Bench for seq_wide_adder (WORDS=4): directed corner cases plus randomized
// traffic against an arithmetic reference model and an expected-result queue.
module tb_seq_wide_adder;

    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
`ifdef ADD_SUB_EN
    logic         sub = 1'b0;
`endif
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int total = 0;
    int bad   = 0;

    seq_wide_adder #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: {cout,sum} is the plain (W+1)-bit result of the operation.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
        logic [W:0] r;
        if (s) r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        else   r = {1'b0, x} + {1'b0, y} + (W+1)'(c);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic eff_sub(input logic s);
`ifdef ADD_SUB_EN
        return s;
`else
        return 1'b0 & s;
`endif
    endfunction

    task automatic drive_ops(input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic c, input logic s);
        a   = x;
        b   = y;
        cin = c;
`ifdef ADD_SUB_EN
        sub = s;
`endif
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input logic s, input int hold);
        int         n;
        logic [W:0] exp;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check_val({tag, "_ready"}, in_ready, 1);
        drive_ops(x, y, c, s);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_val({tag, "_busy"}, busy, 1);
        check_val({tag, "_ov_early"}, out_valid, 0);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check_val({tag, "_latency"}, n, WORDS);
        exp = model(x, y, c, eff_sub(s));
        check_val({tag, "_sum"}, sum, exp[W-1:0]);
        check_val({tag, "_cout"}, cout, exp[W]);
        for (int k = 0; k < hold; k++) begin
            if (k == 3) begin
                drive_ops(~x, y ^ 32'h55, ~c, s);
                in_valid = 1'b1;
            end
            tick();
            in_valid = 1'b0;
            check_val({tag, "_hold_sum"}, sum, exp[W-1:0]);
            check_val({tag, "_hold_cout"}, cout, exp[W]);
            check_val({tag, "_hold_ov"}, out_valid, 1);
            check_val({tag, "_hold_rdy"}, in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val({tag, "_ov_clr"}, out_valid, 0);
        check_val({tag, "_idle"}, in_ready, 1);
        check_val({tag, "_notbusy"}, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W:0] q[$];
        logic [W:0] exp;
        int         acc;
        int         dlv;
        int         cyc;

        #1;
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_sum", sum, 0);
        check_val("rst_cout", cout, 0);
        check_val("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        do_op("carry8", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
        do_op("chain", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0);
        do_op("hold", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 10);

        // Abort an operation while slice 2 is being computed.
        drive_ops(32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_ov", out_valid, 0);
        check_val("mid_rst_sum", sum, 0);
        check_val("mid_rst_cout", cout, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < WORDS + 3; k++) begin
            tick();
            check_val("post_rst_no_ov", out_valid, 0);
        end
        do_op("after_rst", 32'd1, 32'd2, 1'b0, 1'b0, 0);

`ifdef ADD_SUB_EN
        do_op("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 0);
        do_op("sub_pos", 32'd7, 32'd5, 1'b1, 1'b1, 0);
`endif

        acc = 0;
        dlv = 0;
        cyc = 0;
        while ((acc < 1000 || q.size() > 0 || out_valid) && cyc < 40000) begin
            in_valid  = (acc < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            a         = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
            b         = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            cin       = 1'($urandom_range(0, 1));
`ifdef ADD_SUB_EN
            sub       = 1'($urandom_range(0, 1));
`endif
            out_ready = 1'($urandom_range(0, 1));
            #0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check_val("rnd_spurious", out_valid, 0);
                end else begin
                    exp = q.pop_front();
                    check_val("rnd_sum", sum, exp[W-1:0]);
                    check_val("rnd_cout", cout, exp[W]);
                    dlv++;
                end
            end
            if (in_valid && in_ready) begin
`ifdef ADD_SUB_EN
                q.push_back(model(a, b, cin, sub));
`else
                q.push_back(model(a, b, cin, 1'b0));
`endif
                acc++;
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_val("rnd_accepted", acc, 1000);
        check_val("rnd_delivered", dlv, 1000);
        check_val("rnd_queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
